// File: rtl/i2c_pkg.sv
// Shared types and waveform constants for the EEPROM I2C initiator.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STOP   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_ACKBIT = 3'd4,
    ST_DONE   = 3'd5
  } i2c_state_t;

  // {scl,sda} for Q0..Q3, Q0 in the top two bits
  localparam logic [7:0] START_WAVE = 8'b01_11_10_00;
  localparam logic [7:0] STOP_WAVE  = 8'b00_10_11_11;

  localparam int QCNT_W = 8;

  function automatic logic [1:0] wave_phase(input logic [7:0] wave, input logic [1:0] q);
    logic [1:0] pair;
    case (q)
      2'd0:    pair = wave[7:6];
      2'd1:    pair = wave[5:4];
      2'd2:    pair = wave[3:2];
      default: pair = wave[1:0];
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period divider: counts clk_ce pulses 0..QDIV-1 and flags the last one.
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic i_clk,
  input  logic i_clk_ce,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  logic [QCNT_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == QCNT_W'(QDIV - 1));
  assign o_tick = i_clk_ce & w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clk_ce) begin
      if (i_clear || w_last) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C initiator for the cartridge EEPROM; turns START/STOP/WRITE/READ
// commands into registered SCL/SDA quarter-phase waveforms.
//
// state   | meaning
// IDLE    | waiting for a command, bus lines held at their last value
// START   | four quarters of the start / repeated-start waveform
// STOP    | four quarters of the stop waveform, bus released at the end
// SHIFT   | eight data bits, MSB first
// ACKBIT  | ninth bit: slave ack on WRITE, master ack/nack on READ
// DONE    | one clk_ce cycle of done, then back to IDLE
module i2c_master
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic       i_clk,
  input  logic       i_clk_ce,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_nack,
  output logic [7:0] o_rd_data,
  output logic       o_ack_nack,
  output logic       o_done,
  output logic       o_scl,
  output logic       o_sda_out,
  input  logic       i_sda_in
);

  i2c_state_t r_state;
  i2c_cmd_t   r_cmd;
  logic [1:0] r_quarter;
  logic [3:0] r_bit;
  logic [7:0] r_shift;
  logic       r_nack;
  logic       r_scl;
  logic       r_sda;
  logic       r_cmd_ready;
  logic       r_done;
  logic [7:0] r_rd_data;
  logic       r_ack_nack;

  logic w_tick;
  logic w_clear;

  // cmd_ready is only high in IDLE/DONE, so this is exactly the acceptance condition
  assign w_clear = i_cmd_valid & r_cmd_ready;

  i2c_qtick #(
    .QDIV(QDIV)
  ) u_qtick (
    .i_clk   (i_clk),
    .i_clk_ce(i_clk_ce),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_START;
      r_quarter   <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_nack      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_rd_data   <= '0;
      r_ack_nack  <= 1'b1;
    end else if (i_clk_ce) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          if (i_cmd_valid) begin
            r_cmd       <= i2c_cmd_t'(i_cmd);
            r_nack      <= i_rd_nack;
            r_shift     <= i_wr_data;
            r_cmd_ready <= 1'b0;
            r_quarter   <= '0;
            r_bit       <= '0;
            case (i2c_cmd_t'(i_cmd))
              CMD_START: begin
                r_state        <= ST_START;
                {r_scl, r_sda} <= wave_phase(START_WAVE, 2'd0);
              end
              CMD_STOP: begin
                r_state        <= ST_STOP;
                {r_scl, r_sda} <= wave_phase(STOP_WAVE, 2'd0);
              end
              CMD_WRITE: begin
                r_state <= ST_SHIFT;
                r_scl   <= 1'b0;
                r_sda   <= i_wr_data[7];
              end
              default: begin
                r_state <= ST_SHIFT;
                r_scl   <= 1'b0;
                r_sda   <= 1'b1;
              end
            endcase
          end
        end

        ST_START, ST_STOP: begin
          if (w_tick) begin
            r_quarter <= r_quarter + 1'b1;
            if (r_quarter == 2'd3) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
            end else begin
              {r_scl, r_sda} <= wave_phase((r_state == ST_START) ? START_WAVE : STOP_WAVE,
                                           r_quarter + 2'd1);
            end
          end
        end

        ST_SHIFT, ST_ACKBIT: begin
          if (w_tick) begin
            r_quarter <= r_quarter + 1'b1;
            if (r_quarter == 2'd0) r_scl <= 1'b1;
            // sda_in is sampled on the last clk_ce of the high-SCL Q2 quarter
            if (r_quarter == 2'd2) begin
              r_scl <= 1'b0;
              if (r_state == ST_SHIFT) begin
                if (r_cmd == CMD_READ) r_shift <= {r_shift[6:0], i_sda_in};
              end else if (r_cmd == CMD_WRITE) begin
                r_ack_nack <= i_sda_in;
              end
            end
            if (r_quarter == 2'd3) begin
              if (r_state == ST_SHIFT) begin
                if (r_bit == 4'd7) begin
                  r_state <= ST_ACKBIT;
                  r_sda   <= (r_cmd == CMD_WRITE) ? 1'b1 : r_nack;
                end else begin
                  r_bit <= r_bit + 1'b1;
                  if (r_cmd == CMD_WRITE) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_sda   <= r_shift[6];
                  end
                end
              end else begin
                r_state     <= ST_DONE;
                r_done      <= 1'b1;
                r_cmd_ready <= 1'b1;
                if (r_cmd == CMD_READ) r_rd_data <= r_shift;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_done      = r_done;
  assign o_scl       = r_scl;
  assign o_sda_out   = r_sda;
  assign o_rd_data   = r_rd_data;
  assign o_ack_nack  = r_ack_nack;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: per-scenario tasks against a quarter-phase waveform model.
module tb_i2c_master;

  localparam int QDIV = 2;
  localparam int MAXK = 36 * QDIV + 8;
  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic       clk = 1'b0;
  logic       i_clk_ce, i_reset, i_cmd_valid, i_rd_nack, i_sda_in;
  logic [1:0] i_cmd;
  logic [7:0] i_wr_data;
  logic       o_cmd_ready, o_ack_nack, o_done, o_scl, o_sda_out;
  logic [7:0] o_rd_data;

  int total = 0;
  int bad   = 0;

  logic [1:0] cap_wave  [0:MAXK+1];
  logic       cap_done  [0:MAXK+1];
  logic       cap_ready [0:MAXK+1];
  logic [7:0] cap_rd    [0:MAXK+1];
  int         done_k;
  int         ce_zero_changes;
  int         first_bad;

  always #5 clk = ~clk;

  i2c_master #(.QDIV(QDIV)) dut (
    .i_clk      (clk),
    .i_clk_ce   (i_clk_ce),
    .i_reset    (i_reset),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd      (i_cmd),
    .i_wr_data  (i_wr_data),
    .i_rd_nack  (i_rd_nack),
    .o_rd_data  (o_rd_data),
    .o_ack_nack (o_ack_nack),
    .o_done     (o_done),
    .o_scl      (o_scl),
    .o_sda_out  (o_sda_out),
    .i_sda_in   (i_sda_in)
  );

  function automatic int dur_of(input logic [1:0] c);
    return (c == C_START || c == C_STOP) ? 4 * QDIV : 36 * QDIV;
  endfunction

  // Expected {scl,sda} during clk_ce cycle k (k=1 is the cycle after acceptance)
  function automatic logic [1:0] exp_wave(input logic [1:0] c, input logic [7:0] wr,
                                          input logic nack, input int k);
    int q, b;
    logic s, h;
    logic [7:0] t;
    logic [1:0] r;
    q = ((k - 1) / QDIV) % 4;
    b = (k - 1) / (4 * QDIV);
    h = (q == 1 || q == 2);
    t = wr << b;
    if (b < 8) s = (c == C_WRITE) ? t[7] : 1'b1;
    else       s = (c == C_WRITE) ? 1'b1 : nack;
    r = {h, s};
    if (c == C_START) r = (q == 0) ? 2'b01 : (q == 1) ? 2'b11 : (q == 2) ? 2'b10 : 2'b00;
    if (c == C_STOP)  r = (q == 0) ? 2'b00 : (q == 1) ? 2'b10 : 2'b11;
    return r;
  endfunction

  function automatic int wave_errs(input logic [1:0] c, input logic [7:0] wr, input logic nack);
    int n;
    n = 0;
    first_bad = -1;
    for (int k = 1; k <= dur_of(c); k++) begin
      if (cap_wave[k] !== exp_wave(c, wr, nack, k) || cap_done[k] !== 1'b0) begin
        n++;
        if (first_bad < 0) first_bad = k;
      end
    end
    return n;
  endfunction

  // Issue one command, then record outputs once per clk_ce cycle until one cycle past done.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wr, input logic nack,
                         input logic [7:0] sbyte, input logic sack, input int ce_div,
                         input int inj_k);
    int k, cyc, b;
    logic prev_ce;
    logic [3:0] prev4, cur4;
    logic [7:0] t;
    for (int i = 0; i <= MAXK + 1; i++) begin
      cap_wave[i] = 'x; cap_done[i] = 1'bx; cap_ready[i] = 1'bx; cap_rd[i] = 'x;
    end
    @(negedge clk);
    i_clk_ce = 1'b1; i_cmd_valid = 1'b1; i_cmd = c; i_wr_data = wr; i_rd_nack = nack;
    i_sda_in = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    k = 1; cyc = 0; done_k = 0; ce_zero_changes = 0; prev_ce = 1'b1;
    prev4 = {o_scl, o_sda_out, o_done, o_cmd_ready};
    while (k <= MAXK && (done_k == 0 || k <= done_k + 1)) begin
      cur4 = {o_scl, o_sda_out, o_done, o_cmd_ready};
      if (!prev_ce && cur4 !== prev4) ce_zero_changes++;
      prev4 = cur4;
      i_clk_ce = ((cyc % ce_div) == 0);
      cyc++;
      i_cmd_valid = 1'b0;
      if (i_clk_ce) begin
        cap_wave[k] = {o_scl, o_sda_out}; cap_done[k] = o_done;
        cap_ready[k] = o_cmd_ready; cap_rd[k] = o_rd_data;
        if (o_done === 1'b1 && done_k == 0) done_k = k;
        b = (k - 1) / (4 * QDIV);
        t = ((c == C_READ) ? sbyte : wr) << b;
        if (b < 8)       i_sda_in = t[7];
        else if (b == 8) i_sda_in = (c == C_READ) ? nack : sack;
        else             i_sda_in = 1'b1;
        if (k == inj_k) begin i_cmd_valid = 1'b1; i_cmd = C_STOP; end
        k++;
      end
      prev_ce = i_clk_ce;
      @(negedge clk);
    end
    i_clk_ce = 1'b1; i_cmd_valid = 1'b0; i_sda_in = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    total++; if (o_scl !== 1'b1) begin bad++; $display("FAIL rst_scl got=%b want=1", o_scl); end
    total++; if (o_sda_out !== 1'b1) begin bad++; $display("FAIL rst_sda got=%b want=1", o_sda_out); end
    total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", o_cmd_ready); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", o_done); end
    total++; if (o_rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%h want=00", o_rd_data); end
    total++; if (o_ack_nack !== 1'b1) begin bad++; $display("FAIL rst_ack got=%b want=1", o_ack_nack); end
  endtask

  task automatic test_framing(input logic [1:0] c, input logic [1:0] idle_exp);
    int n, d;
    d = dur_of(c);
    run_cmd(c, 8'h00, 1'b0, 8'h00, 1'b0, 1, 0);
    n = wave_errs(c, 8'h00, 1'b0);
    total++; if (n !== 0) begin bad++; $display("FAIL frame_wave cmd=%0d errs=%0d first_k=%0d want=0", c, n, first_bad); end
    total++; if (done_k !== d + 1 || cap_done[d+2] !== 1'b0) begin
      bad++; $display("FAIL frame_done cmd=%0d got_k=%0d want_k=%0d", c, done_k, d + 1); end
    total++; if (cap_ready[d] !== 1'b0 || cap_ready[d+1] !== 1'b1) begin
      bad++; $display("FAIL frame_ready cmd=%0d got=%b%b want=01", c, cap_ready[d], cap_ready[d+1]); end
    repeat (3) @(negedge clk);
    total++; if ({o_scl, o_sda_out} !== idle_exp) begin
      bad++; $display("FAIL frame_idle cmd=%0d got=%b want=%b", c, {o_scl, o_sda_out}, idle_exp); end
  endtask

  task automatic test_write(input logic [7:0] wr, input logic sack);
    int n, d;
    d = dur_of(C_WRITE);
    run_cmd(C_WRITE, wr, 1'b0, 8'h00, sack, 1, 0);
    n = wave_errs(C_WRITE, wr, 1'b0);
    total++; if (n !== 0) begin bad++; $display("FAIL write_wave data=%h errs=%0d first_k=%0d want=0", wr, n, first_bad); end
    total++; if (done_k !== d + 1) begin bad++; $display("FAIL write_done got_k=%0d want_k=%0d", done_k, d + 1); end
    total++; if (o_ack_nack !== sack) begin bad++; $display("FAIL write_ack got=%b want=%b", o_ack_nack, sack); end
    total++; if ({o_scl, o_sda_out} !== 2'b01) begin bad++; $display("FAIL write_idle got=%b want=01", {o_scl, o_sda_out}); end
  endtask

  task automatic test_read(input logic [7:0] sbyte, input logic nack, input int ce_div);
    int n, d;
    logic [7:0] rd_before;
    d = dur_of(C_READ);
    rd_before = o_rd_data;
    run_cmd(C_READ, 8'h00, nack, sbyte, 1'b0, ce_div, 0);
    n = wave_errs(C_READ, 8'h00, nack);
    total++; if (n !== 0) begin bad++; $display("FAIL read_wave data=%h errs=%0d first_k=%0d want=0", sbyte, n, first_bad); end
    total++; if (done_k !== d + 1) begin bad++; $display("FAIL read_done got_k=%0d want_k=%0d", done_k, d + 1); end
    total++; if (cap_rd[d] !== rd_before || cap_rd[d+1] !== sbyte) begin
      bad++; $display("FAIL read_data before=%h at_done=%h want %h then %h", cap_rd[d], cap_rd[d+1], rd_before, sbyte); end
    if (ce_div > 1) begin
      total++; if (ce_zero_changes !== 0) begin
        bad++; $display("FAIL slow_ce_hold changes=%0d want=0", ce_zero_changes); end
    end
  endtask

  task automatic test_ignore_busy();
    int n, d;
    d = dur_of(C_WRITE);
    run_cmd(C_WRITE, 8'h3C, 1'b0, 8'h00, 1'b0, 1, 5 * 4 * QDIV + 3);
    n = wave_errs(C_WRITE, 8'h3C, 1'b0);
    total++; if (n !== 0) begin bad++; $display("FAIL busy_wave errs=%0d first_k=%0d want=0", n, first_bad); end
    total++; if (done_k !== d + 1) begin bad++; $display("FAIL busy_done got_k=%0d want_k=%0d", done_k, d + 1); end
    repeat (4 * QDIV + 2) @(negedge clk);
    total++; if (o_scl !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL busy_queued scl=%b ready=%b want scl=0 ready=1", o_scl, o_cmd_ready); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd = C_WRITE; i_wr_data = 8'hFF;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (16 * QDIV) @(negedge clk);
    total++; if (o_scl !== 1'b0 || o_cmd_ready !== 1'b0) begin
      bad++; $display("FAIL mid_pre scl=%b ready=%b want 0 0", o_scl, o_cmd_ready); end
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    total++; if (o_scl !== 1'b1) begin bad++; $display("FAIL mid_scl got=%b want=1", o_scl); end
    total++; if (o_sda_out !== 1'b1) begin bad++; $display("FAIL mid_sda got=%b want=1", o_sda_out); end
    total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", o_cmd_ready); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", o_done); end
    total++; if (o_rd_data !== 8'h00) begin bad++; $display("FAIL mid_rd_data got=%h want=00", o_rd_data); end
    total++; if (o_ack_nack !== 1'b1) begin bad++; $display("FAIL mid_ack got=%b want=1", o_ack_nack); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic       a;
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) test_write(v, a);
      else                           test_read(v, a, 1);
    end
  endtask

  initial begin
    i_clk_ce = 1'b1; i_reset = 1'b0; i_cmd_valid = 1'b0; i_cmd = C_START;
    i_wr_data = 8'h00; i_rd_nack = 1'b0; i_sda_in = 1'b1;
    test_reset();
    test_framing(C_START, 2'b00);
    test_write(8'hA0, 1'b1);
    test_write(8'hA0, 1'b0);
    test_read(8'h5A, 1'b1, 1);
    test_reset_mid();
    test_framing(C_STOP, 2'b11);
    test_framing(C_START, 2'b00);
    test_ignore_busy();
    test_read($urandom_range(0, 255), 1'b0, 3);
    test_random();
    test_framing(C_STOP, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
